// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg -- shared types for the vector pipeline hazard controller.
//   fwd_sel_t : execute-stage operand source select (regfile / M / W)
//   vstate_t  : vector-hold FSM states
//   fwd_pick  : forwarding priority helper, M result is newer than W
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_M  = 2'b01,
      FWD_W  = 2'b10
   } fwd_sel_t;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      VBUSY = 1'b1
   } vstate_t;

   function automatic fwd_sel_t fwd_pick(input logic hit_m, input logic hit_w);
      if (hit_m)      return FWD_M;
      else if (hit_w) return FWD_W;
      else            return FWD_RF;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if -- pipeline-side bundle for the hazard controller.
//   Stage info in : D sources/uses, E dest/sources/flags, M and W dest/flags
//   Control out   : stall_F/D/E, flush_D/E, fwdA_E/fwdB_E, stall_cnt
//   modport master: pipeline datapath (drives stage info, receives control)
//   modport slave : hazard controller
interface pipe_hazard_ctrl_if #(
   parameter int M  = 4,
   parameter int CW = 16
);
   logic [M-1:0]  regAD, regBD;
   logic          useA_D, useB_D, vect_D;
   logic [M-1:0]  regScr_E, regAE, regBE;
   logic          regw_E, regmem_E, vect_E, ALUope_E, branch_E, br_taken_E;
   logic [M-1:0]  regScr_M;
   logic          regw_M, vect_M;
   logic [M-1:0]  regScr_W;
   logic          regw_W, vect_W;
   logic          stall_F, stall_D, stall_E, flush_D, flush_E;
   logic [1:0]    fwdA_E, fwdB_E;
   logic [CW-1:0] stall_cnt;

   modport master (
      output regAD, regBD, useA_D, useB_D, vect_D,
             regScr_E, regAE, regBE, regw_E, regmem_E, vect_E, ALUope_E,
             branch_E, br_taken_E, regScr_M, regw_M, vect_M,
             regScr_W, regw_W, vect_W,
      input  stall_F, stall_D, stall_E, flush_D, flush_E,
             fwdA_E, fwdB_E, stall_cnt
   );

   modport slave (
      input  regAD, regBD, useA_D, useB_D, vect_D,
             regScr_E, regAE, regBE, regw_E, regmem_E, vect_E, ALUope_E,
             branch_E, br_taken_E, regScr_M, regw_M, vect_M,
             regScr_W, regw_W, vect_W,
      output stall_F, stall_D, stall_E, flush_D, flush_E,
             fwdA_E, fwdB_E, stall_cnt
   );
endinterface

// File: rtl/hazard_match.sv
// hazard_match -- one producer/consumer register dependence compare.
//   idx, vect, regw  : producer destination index, vector flag, write enable
//   src, vect_src    : consumer source index and vector flag
//   used             : consumer really reads this source
//   hit              : dependence exists
// Scalar and vector files share the index space, so the vect flags must agree.
module hazard_match #(
   parameter int W = 4
) (
   input  logic [W-1:0] idx,
   input  logic         vect,
   input  logic         regw,
   input  logic [W-1:0] src,
   input  logic         vect_src,
   input  logic         used,
   output logic         hit
);
   assign hit = regw & used & (idx == src) & (vect == vect_src);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl -- stall/flush/forward controller for the 5-stage vector pipe.
//   clk   : pipeline clock
//   rst   : asynchronous active-low reset
//   bus   : pipe_hazard_ctrl_if.slave (stage info in, stall/flush/fwd/stall_cnt out)
// Parameters: M register-index width, VLAT vector ALU latency, CW stall counter width.
// Build option PIPE_FWD_EN: when defined, E-stage operands are forwarded from M/W
// and only load-use stalls; when undefined, fwd selects are fixed to the regfile
// and any D-stage read of an E or M destination stalls until the producer leaves M.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int M    = 4,
   parameter int VLAT = 4,
   parameter int CW   = 16
) (
   input  logic               clk,
   input  logic               rst,
   pipe_hazard_ctrl_if.slave  bus
);

   localparam logic [0:0] ST_IDLE  = IDLE;
   localparam logic [0:0] ST_VBUSY = VBUSY;

   // vcnt counts the remaining VBUSY cycles after the first one
   localparam int            VW    = (VLAT > 2) ? $clog2(VLAT - 1) : 1;
   localparam logic [VW-1:0] VLOAD = VW'((VLAT > 2) ? VLAT - 2 : 0);

   logic [0:0]    state;
   logic [VW-1:0] vcnt;
   logic          held;
   logic [CW-1:0] stall_cnt_q;
   logic          busy, vtrig, ld_use, raw;
   logic          stall_F, stall_D, stall_E, flush_D, flush_E;
   logic [1:0]    hit_ed;

   // E destination vs D sources: load-use (and RAW when not forwarding)
   hazard_match #(.W(M)) u_ed [1:0] (
      .idx(bus.regScr_E), .vect(bus.vect_E), .regw(bus.regw_E),
      .src({bus.regBD, bus.regAD}), .vect_src(bus.vect_D),
      .used({bus.useB_D, bus.useA_D}), .hit(hit_ed)
   );

   assign ld_use = bus.regmem_E & (|hit_ed);

`ifdef PIPE_FWD_EN
   logic [1:0] hit_fm, hit_fw;

   hazard_match #(.W(M)) u_fm [1:0] (
      .idx(bus.regScr_M), .vect(bus.vect_M), .regw(bus.regw_M),
      .src({bus.regBE, bus.regAE}), .vect_src(bus.vect_E),
      .used(2'b11), .hit(hit_fm)
   );

   hazard_match #(.W(M)) u_fw [1:0] (
      .idx(bus.regScr_W), .vect(bus.vect_W), .regw(bus.regw_W),
      .src({bus.regBE, bus.regAE}), .vect_src(bus.vect_E),
      .used(2'b11), .hit(hit_fw)
   );

   // M/W producers are bypassed, so only load-use needs a bubble
   assign raw        = 1'b0;
   assign bus.fwdA_E = rst ? fwd_pick(hit_fm[0], hit_fw[0]) : FWD_RF;
   assign bus.fwdB_E = rst ? fwd_pick(hit_fm[1], hit_fw[1]) : FWD_RF;
`else
   logic [1:0] hit_md;
   logic       unused_nofwd;

   hazard_match #(.W(M)) u_md [1:0] (
      .idx(bus.regScr_M), .vect(bus.vect_M), .regw(bus.regw_M),
      .src({bus.regBD, bus.regAD}), .vect_src(bus.vect_D),
      .used({bus.useB_D, bus.useA_D}), .hit(hit_md)
   );

   // W needs no stall: the regfile writes before it is read in D
   assign raw          = (|hit_ed) | (|hit_md);
   assign bus.fwdA_E   = FWD_RF;
   assign bus.fwdB_E   = FWD_RF;
   assign unused_nofwd = ^{bus.regAE, bus.regBE, bus.regScr_W, bus.regw_W, bus.vect_W};
`endif

   assign busy = (state == ST_VBUSY);
   // held blocks a retrigger by the same op on the cycle right after its hold ends
   assign vtrig = bus.vect_E & bus.ALUope_E & (VLAT > 1) & ~held;

   // outputs are forced low while reset is asserted, independent of inputs
   always_comb begin
      stall_F = 1'b0;
      stall_D = 1'b0;
      stall_E = 1'b0;
      flush_D = 1'b0;
      flush_E = 1'b0;
      if (rst) begin
         if (busy) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            stall_E = 1'b1;
         end else if (bus.branch_E & bus.br_taken_E) begin
            flush_D = 1'b1;
            flush_E = 1'b1;
         end else if (ld_use | raw) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            flush_E = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         vcnt        <= '0;
         held        <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         held <= busy;
         case (state)
            ST_IDLE: begin
               if (vtrig) begin
                  state <= ST_VBUSY;
                  vcnt  <= VLOAD;
               end
            end
            default: begin
               if (vcnt == '0) state <= ST_IDLE;
               else            vcnt  <= vcnt - 1'b1;
            end
         endcase
         if (stall_D && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + 1'b1;
      end
   end

   assign bus.stall_F   = stall_F;
   assign bus.stall_D   = stall_D;
   assign bus.stall_E   = stall_E;
   assign bus.flush_D   = flush_D;
   assign bus.flush_E   = flush_E;
   assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl -- randomized + directed bench for pipe_hazard_ctrl.
// A behavioural model (remaining-hold counter, rule-based hazard checks,
// saturating stall counter) predicts every cycle's outputs. Honours PIPE_FWD_EN.
module tb_pipe_hazard_ctrl;

   localparam int M    = 4;
   localparam int VLAT = 4;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

`ifdef PIPE_FWD_EN
   localparam logic [1:0] EXP_FWD_MW = 2'b01;
   localparam logic [1:0] EXP_FWD_W  = 2'b10;
   localparam int         RAW_STALLS = 0;
`else
   localparam logic [1:0] EXP_FWD_MW = 2'b00;
   localparam logic [1:0] EXP_FWD_W  = 2'b00;
   localparam int         RAW_STALLS = 2;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.M(M), .CW(CW)) bus();

   pipe_hazard_ctrl #(.M(M), .VLAT(VLAT), .CW(CW)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   int n_chk = 0;
   int n_err = 0;

   // model state
   int         vleft   = 0;   // hold cycles still owed to the current vector op
   bit         blocked = 0;   // op just finished its hold, may still sit in E
   int         cnt     = 0;
   logic [4:0] e_ctl;         // {stall_F, stall_D, stall_E, flush_D, flush_E}
   logic [1:0] e_fa, e_fb;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit mt(input logic [M-1:0] i, input logic v, input logic w,
                             input logic [M-1:0] s, input logic vs, input logic u);
      return w && u && (i == s) && (v == vs);
   endfunction

   function automatic logic [4:0] dut_ctl();
      return {bus.stall_F, bus.stall_D, bus.stall_E, bus.flush_D, bus.flush_E};
   endfunction

   task automatic model_eval();
      bit busy, lu, raw, ea, eb;
      busy = (vleft > 0);
      e_fa = 2'b00;
      e_fb = 2'b00;
      e_ctl = 5'b0;
      ea = mt(bus.regScr_E, bus.vect_E, bus.regw_E, bus.regAD, bus.vect_D, bus.useA_D);
      eb = mt(bus.regScr_E, bus.vect_E, bus.regw_E, bus.regBD, bus.vect_D, bus.useB_D);
      lu = bus.regmem_E && (ea || eb);
`ifdef PIPE_FWD_EN
      raw = 0;
      if (mt(bus.regScr_M, bus.vect_M, bus.regw_M, bus.regAE, bus.vect_E, 1'b1))      e_fa = 2'b01;
      else if (mt(bus.regScr_W, bus.vect_W, bus.regw_W, bus.regAE, bus.vect_E, 1'b1)) e_fa = 2'b10;
      if (mt(bus.regScr_M, bus.vect_M, bus.regw_M, bus.regBE, bus.vect_E, 1'b1))      e_fb = 2'b01;
      else if (mt(bus.regScr_W, bus.vect_W, bus.regw_W, bus.regBE, bus.vect_E, 1'b1)) e_fb = 2'b10;
`else
      raw = ea || eb ||
            mt(bus.regScr_M, bus.vect_M, bus.regw_M, bus.regAD, bus.vect_D, bus.useA_D) ||
            mt(bus.regScr_M, bus.vect_M, bus.regw_M, bus.regBD, bus.vect_D, bus.useB_D);
`endif
      if (busy)                               e_ctl = 5'b11100;
      else if (bus.branch_E && bus.br_taken_E) e_ctl = 5'b00011;
      else if (lu || raw)                      e_ctl = 5'b11001;
      if (!rst) begin
         e_ctl = 5'b0;
         e_fa  = 2'b00;
         e_fb  = 2'b00;
      end
   endtask

   task automatic model_update();
      if (e_ctl[3] && cnt < CMAX) cnt++;
      if (vleft > 0) begin
         vleft--;
         blocked = 1;
      end else begin
         if (!blocked && bus.vect_E && bus.ALUope_E && VLAT > 1) vleft = VLAT - 1;
         blocked = 0;
      end
   endtask

   // inputs are set before the call (posedge+1); outputs are checked at negedge
   task automatic run_cycle();
      @(negedge clk);
      model_eval();
      chk("ctl",  32'(dut_ctl()),     32'(e_ctl));
      chk("fwdA", 32'(bus.fwdA_E),    32'(e_fa));
      chk("fwdB", 32'(bus.fwdB_E),    32'(e_fb));
      chk("cnt",  32'(bus.stall_cnt), 32'(cnt));
      @(posedge clk);
      if (rst) model_update();
      #1;
   endtask

   task automatic clear_in();
      bus.regAD = '0; bus.regBD = '0; bus.useA_D = 0; bus.useB_D = 0; bus.vect_D = 0;
      bus.regScr_E = '0; bus.regAE = '0; bus.regBE = '0;
      bus.regw_E = 0; bus.regmem_E = 0; bus.vect_E = 0; bus.ALUope_E = 0;
      bus.branch_E = 0; bus.br_taken_E = 0;
      bus.regScr_M = '0; bus.regw_M = 0; bus.vect_M = 0;
      bus.regScr_W = '0; bus.regw_W = 0; bus.vect_W = 0;
   endtask

   task automatic set_load_use();
      bus.regScr_E = 4'd3; bus.regw_E = 1; bus.regmem_E = 1;
      bus.regAD = 4'd3; bus.useA_D = 1;
   endtask

   task automatic rand_in();
      bus.regAD = M'($urandom_range(0, 3)); bus.regBD = M'($urandom_range(0, 3));
      bus.useA_D = 1'($urandom); bus.useB_D = 1'($urandom);
      bus.vect_D = ($urandom_range(0, 3) == 0);
      bus.regScr_E = M'($urandom_range(0, 3));
      bus.regAE = M'($urandom_range(0, 3)); bus.regBE = M'($urandom_range(0, 3));
      bus.regw_E = 1'($urandom); bus.regmem_E = ($urandom_range(0, 2) == 0);
      bus.vect_E = ($urandom_range(0, 3) == 0); bus.ALUope_E = ($urandom_range(0, 1) == 0);
      bus.branch_E = ($urandom_range(0, 5) == 0); bus.br_taken_E = 1'($urandom);
      bus.regScr_M = M'($urandom_range(0, 3)); bus.regw_M = 1'($urandom);
      bus.vect_M = ($urandom_range(0, 3) == 0);
      bus.regScr_W = M'($urandom_range(0, 3)); bus.regw_W = 1'($urandom);
      bus.vect_W = ($urandom_range(0, 3) == 0);
   endtask

   initial begin
      clear_in();
      // reset with a live load-use and forwardable pattern: outputs must stay 0
      set_load_use();
      bus.regScr_M = 4'd5; bus.regw_M = 1; bus.regAE = 4'd5;
      #12;
      chk("rst_ctl",  32'(dut_ctl()),     32'd0);
      chk("rst_fwdA", 32'(bus.fwdA_E),    32'd0);
      chk("rst_cnt",  32'(bus.stall_cnt), 32'd0);
      @(posedge clk); #1;
      clear_in();
      rst = 1;
      run_cycle();

      // vector op: three hold cycles, released on the fourth
      clear_in(); bus.vect_E = 1; bus.ALUope_E = 1;
      repeat (VLAT + 1) run_cycle();
      chk("vec_cnt", 32'(bus.stall_cnt), 32'd3);
      clear_in(); run_cycle();

      // load-use: one stall cycle, then quiet
      set_load_use(); run_cycle();
      chk("lu_cnt", 32'(bus.stall_cnt), 32'd4);
      clear_in(); run_cycle();

      // taken branch beats load-use
      set_load_use(); bus.branch_E = 1; bus.br_taken_E = 1;
      #1;
      chk("br_ctl", 32'(dut_ctl()), 32'b00011);
      run_cycle();
      chk("br_cnt", 32'(bus.stall_cnt), 32'd4);

      // forwarding priority and vector-flag mismatch
      clear_in();
      bus.regScr_M = 4'd5; bus.regw_M = 1; bus.regScr_W = 4'd5; bus.regw_W = 1; bus.regAE = 4'd5;
      #1; chk("fwd_mw", 32'(bus.fwdA_E), 32'(EXP_FWD_MW)); run_cycle();
      bus.regw_M = 0;
      #1; chk("fwd_w", 32'(bus.fwdA_E), 32'(EXP_FWD_W)); run_cycle();
      bus.vect_W = 1;
      #1; chk("fwd_vm", 32'(bus.fwdA_E), 32'd0); run_cycle();

      // ADD r2 walks E -> M -> W while D keeps reading r2
      clear_in();
      bus.regScr_E = 4'd2; bus.regw_E = 1; bus.regAD = 4'd2; bus.useA_D = 1;
      run_cycle();
      bus.regw_E = 0; bus.regScr_M = 4'd2; bus.regw_M = 1;
      run_cycle();
      bus.regw_M = 0; bus.regScr_W = 4'd2; bus.regw_W = 1;
      run_cycle();
      chk("raw_cnt", 32'(bus.stall_cnt), 32'(4 + RAW_STALLS));

      // randomized traffic
      repeat (400) begin
         rand_in();
         run_cycle();
      end

      // async reset in the middle of a vector hold
      clear_in(); bus.vect_E = 1; bus.ALUope_E = 1; run_cycle();
      clear_in(); set_load_use(); bus.regScr_M = 4'd1; bus.regw_M = 1; bus.regAE = 4'd1;
      run_cycle();
      rst = 0;
      #1;
      chk("mid_rst_ctl", 32'(dut_ctl()),     32'd0);
      chk("mid_rst_fwd", 32'(bus.fwdA_E),    32'd0);
      chk("mid_rst_cnt", 32'(bus.stall_cnt), 32'd0);
      vleft = 0; blocked = 0; cnt = 0;
      run_cycle();
      rst = 1;
      clear_in(); run_cycle();

      // saturation of the stall counter
      set_load_use();
      repeat (CMAX + 5) run_cycle();
      chk("sat_cnt", 32'(bus.stall_cnt), 32'(CMAX));

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
